mul_writeback: RTL

Sequential 32×32 shift-add multiplier that sits directly downstream of the register file read ports and upstream of its write port. It consumes the two read operands (ReadData1/ReadData2), computes the full 64-bit product over 32 iteration cycles, writes the low word back to a destination register through a request/grant writeback handshake, and holds the high word for later reads. Signed and unsigned multiply are both supported.

---
 rtl/mul_writeback.sv | 126 ++++++++++++
 1 files changed

// File: rtl/mul_writeback.sv
// mul_writeback: sequential shift-add 32x32 multiplier feeding the register
// file write port. Low product word is written back through a req/grant
// handshake; the high word is held on Hi for later reads.
module mul_writeback #(
  parameter int WIDTH = 32,
  parameter int ADDRW = 5
) (
  input  logic             Clk,
  input  logic             Reset_n,
  input  logic             Start,
  input  logic             SignedMode,
  input  logic [WIDTH-1:0] OperandA,
  input  logic [WIDTH-1:0] OperandB,
  input  logic [ADDRW-1:0] DestRegister,
  input  logic             WbGrant,
  output logic             WbReq,
  output logic [WIDTH-1:0] WbData,
  output logic [ADDRW-1:0] WbRegister,
  output logic [WIDTH-1:0] Hi,
  output logic             Busy,
  output logic             Done
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {IDLE, RUN, SIGN, WB} state_t;

  state_t                 state, next_state;
  logic [CW-1:0]          cnt;
  logic [2*WIDTH-1:0]     acc;
  logic [2*WIDTH-1:0]     mcand;
  logic [WIDTH-1:0]       mplier;
  logic                   neg;
  logic [2*WIDTH-1:0]     prod;
  logic                   start_ok;
  logic                   last_iter;
  logic                   done_nxt;

  // Magnitude of an operand; -2^(W-1) maps to 2^(W-1), which still fits unsigned.
  function automatic logic [WIDTH-1:0] magnitude(input logic signed [WIDTH-1:0] v,
                                                 input logic is_signed);
    logic signed [WIDTH-1:0] n;
    n = -v;
    if (is_signed && v < 0) return $unsigned(n);
    return $unsigned(v);
  endfunction

  // Two's-complement negation of the full product, modulo 2^(2W).
  function automatic logic [2*WIDTH-1:0] negate(input logic [2*WIDTH-1:0] v);
    return ~v + (2*WIDTH)'(1);
  endfunction

  assign start_ok  = (state == IDLE) && Start;
  assign last_iter = (cnt == CW'(WIDTH - 1));
  assign prod      = neg ? negate(acc) : acc;

  // Next-state decode and completion detection.
  always_comb begin
    next_state = state;
    done_nxt   = 1'b0;
    case (state)
      IDLE: if (Start) next_state = RUN;
      RUN:  if (last_iter) next_state = SIGN;
      SIGN: begin
        // Register 0 is hardwired zero, so skip the write entirely.
        if (WbRegister != '0) begin
          next_state = WB;
        end else begin
          next_state = IDLE;
          done_nxt   = 1'b1;
        end
      end
      WB: begin
        if (WbGrant) begin
          next_state = IDLE;
          done_nxt   = 1'b1;
        end
      end
      default: next_state = IDLE;
    endcase
  end

  // State, iteration counter and all registered outputs; reset discards any op.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state      <= IDLE;
      cnt        <= '0;
      Busy       <= 1'b0;
      WbReq      <= 1'b0;
      Done       <= 1'b0;
      WbRegister <= '0;
      WbData     <= '0;
      Hi         <= '0;
    end else begin
      state <= next_state;
      Busy  <= (next_state != IDLE);
      WbReq <= (next_state == WB);
      Done  <= done_nxt;
      if (start_ok) begin
        cnt        <= '0;
        WbRegister <= DestRegister;
      end else if (state == RUN) begin
        cnt <= cnt + CW'(1);
      end
      if (state == SIGN) begin
        WbData <= prod[WIDTH-1:0];
        Hi     <= prod[2*WIDTH-1:WIDTH];
      end
    end
  end

  // Shift-add datapath: capture magnitudes at start, one iteration per RUN cycle.
  always_ff @(posedge Clk) begin
    if (start_ok) begin
      mcand  <= {{WIDTH{1'b0}}, magnitude(OperandA, SignedMode)};
      mplier <= magnitude(OperandB, SignedMode);
      acc    <= '0;
      neg    <= SignedMode & (OperandA[WIDTH-1] ^ OperandB[WIDTH-1]);
    end else if (state == RUN) begin
      if (mplier[0]) acc <= acc + mcand;
      mcand  <= mcand << 1;
      mplier <= mplier >> 1;
    end
  end

endmodule
